// File: rtl/axi_dma_wr_wrap.sv
// Write-direction DMA: turns a (addr, len) descriptor plus an AXI-stream payload
// into aligned AXI4 INCR write bursts and pulses a status once all B responses return.
module axi_dma_wr_wrap #(
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ADDR_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 8,
  parameter int LEN_WIDTH         = 9,
  parameter int AXI_MAX_BURST_LEN = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axis_write_desc_addr,
  input  logic [LEN_WIDTH-1:0]        s_axis_write_desc_len,
  input  logic                        s_axis_write_desc_valid,
  output logic                        s_axis_write_desc_ready,
  output logic                        m_axis_write_desc_status_valid,
  output logic [1:0]                  m_axis_write_desc_status_error,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axis_write_data_tdata,
  input  logic                        s_axis_write_data_tvalid,
  output logic                        s_axis_write_data_tready,
  input  logic                        s_axis_write_data_tlast,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awlock,
  output logic [3:0]                  m_axi_awcache,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready
);
  localparam int STRB = AXI_DATA_WIDTH / 8;
  localparam int SZ   = $clog2(STRB);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT_B} state_t;
  state_t state, state_nxt;

  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]      beats_left, desc_beats, outstanding;
  logic [8:0]                beat_cnt;
  logic [1:0]                err;
  logic [31:0]               bnd_beats, burst;
  logic                      desc_hs, aw_hs, w_hs, b_hs;
  logic                      unused_ok;

  assign unused_ok = ^m_axi_bid;

  assign desc_beats = s_axis_write_desc_len >> SZ;
  assign desc_hs    = s_axis_write_desc_valid & s_axis_write_desc_ready;
  assign aw_hs      = m_axi_awvalid & m_axi_awready;
  assign w_hs       = m_axi_wvalid & m_axi_wready;
  assign b_hs       = m_axi_bvalid & m_axi_bready;

  // Burst size: limited by remaining beats, max burst length and the 4 KB page.
  always_comb begin
    bnd_beats = (32'd4096 - {20'd0, addr[11:0]}) >> SZ;
    burst     = 32'(beats_left);
    if (burst > 32'(AXI_MAX_BURST_LEN)) burst = 32'(AXI_MAX_BURST_LEN);
    if (burst > bnd_beats)              burst = bnd_beats;
  end

  // Constant AXI fields
  assign m_axi_awid    = '0;
  assign m_axi_awsize  = 3'(SZ);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wstrb   = '1;

  // Ready drops for the pulse cycle so the next descriptor waits one cycle.
  assign s_axis_write_desc_ready  = (state == IDLE) & ~m_axis_write_desc_status_valid & ~rst;
  assign m_axi_bready             = ~rst;
  assign m_axi_awaddr             = addr;
  assign m_axi_awlen              = (state == ADDR) ? 8'(burst - 32'd1) : 8'd0;
  assign m_axi_awvalid            = (state == ADDR);
  assign m_axi_wdata              = s_axis_write_data_tdata;
  assign m_axi_wvalid             = (state == DATA) & s_axis_write_data_tvalid;
  assign s_axis_write_data_tready = (state == DATA) & m_axi_wready;
  assign m_axi_wlast              = (state == DATA) & (beat_cnt == 9'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (desc_hs) state_nxt = (desc_beats == '0) ? WAIT_B : ADDR;
      ADDR:   if (aw_hs) state_nxt = DATA;
      DATA:   if (w_hs && beat_cnt == 9'd1)
                state_nxt = (beats_left > LEN_WIDTH'(1)) ? ADDR : WAIT_B;
      WAIT_B: if (outstanding == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr                           <= '0;
      beats_left                     <= '0;
      beat_cnt                       <= '0;
      outstanding                    <= '0;
      err                            <= '0;
      m_axis_write_desc_status_valid <= 1'b0;
      m_axis_write_desc_status_error <= '0;
    end else begin
      m_axis_write_desc_status_valid <= 1'b0;
      if (desc_hs) begin
        addr       <= s_axis_write_desc_addr;
        beats_left <= desc_beats;
        err        <= '0;
      end
      if (aw_hs) beat_cnt <= 9'(burst);
      if (w_hs) begin
        beat_cnt   <= beat_cnt - 9'd1;
        beats_left <= beats_left - LEN_WIDTH'(1);
        addr       <= addr + AXI_ADDR_WIDTH'(STRB);
        if (s_axis_write_data_tlast != (beats_left == LEN_WIDTH'(1))) err[1] <= 1'b1;
      end
      if (b_hs && m_axi_bresp != 2'b00) err[0] <= 1'b1;
      case ({aw_hs, b_hs})
        2'b10:   outstanding <= outstanding + LEN_WIDTH'(1);
        2'b01:   outstanding <= outstanding - LEN_WIDTH'(1);
        default: ;
      endcase
      if (state == WAIT_B && outstanding == '0) begin
        m_axis_write_desc_status_valid <= 1'b1;
        m_axis_write_desc_status_error <= err;
      end
    end
  end
endmodule

// File: tb/tb_axi_dma_wr_wrap.sv
// Randomized bench for axi_dma_wr_wrap: slave/stream BFM plus a burst-list reference model.
module tb_axi_dma_wr_wrap;
  localparam int STRB = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] desc_addr = '0;
  logic [8:0]  desc_len = '0;
  logic        desc_valid = 1'b0, desc_ready;
  logic        st_valid;
  logic [1:0]  st_error;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0, tready, tlast = 1'b0;
  logic [7:0]  awid, awlen;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic        awlock, awvalid, wlast, wvalid, bready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0]  awcache, wstrb;
  logic [7:0]  bid = '0;
  logic [1:0]  bresp = '0;

  always #5 clk = ~clk;

  axi_dma_wr_wrap dut (
    .clk(clk), .rst(rst),
    .s_axis_write_desc_addr(desc_addr), .s_axis_write_desc_len(desc_len),
    .s_axis_write_desc_valid(desc_valid), .s_axis_write_desc_ready(desc_ready),
    .m_axis_write_desc_status_valid(st_valid), .m_axis_write_desc_status_error(st_error),
    .s_axis_write_data_tdata(tdata), .s_axis_write_data_tvalid(tvalid),
    .s_axis_write_data_tready(tready), .s_axis_write_data_tlast(tlast),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // BFM state shared with the main sequence
  bit          stall = 0, t_hold = 0, d_pend = 0, prev_st = 0;
  logic [31:0] d_addr = '0;
  logic [8:0]  d_len = '0;
  logic [31:0] s_data[$];
  logic [39:0] aw_log[$];
  logic [32:0] w_log[$];
  int s_idx = 0, s_tlast_at = -1, b_pend = 0, b_cnt = 0, slverr_at = -1;
  int cyc = 0, desc_cyc = 0, aw_first_cyc = -1, st_cyc = 0, st_cnt = 0;
  logic [1:0] st_err = '0;
  logic st_dr = 1'b0, dr_after = 1'b0;

  // Drive on the falling edge, sample 1 time unit before the rising edge.
  always @(negedge clk) begin
    awready = !stall || ($urandom_range(0, 3) != 0);
    wready  = !stall || ($urandom_range(0, 2) != 0);
    if (!t_hold) tvalid = (s_idx < s_data.size()) && (!stall || ($urandom_range(0, 2) != 0));
    if (s_idx < s_data.size()) begin
      tdata = s_data[s_idx];
      tlast = (s_idx == s_tlast_at);
    end else begin
      tdata = '0;
      tlast = 1'b0;
    end
    bvalid = (b_pend > 0) && (!stall || ($urandom_range(0, 2) != 0));
    bresp  = (b_cnt == slverr_at) ? 2'b10 : 2'b00;
    bid    = 8'($urandom);
    desc_valid = d_pend;
    desc_addr  = d_addr;
    desc_len   = d_len;
    #4;
    if (desc_valid && desc_ready) begin
      d_pend = 0; desc_cyc = cyc; aw_first_cyc = -1;
    end
    if (awvalid && aw_first_cyc < 0) aw_first_cyc = cyc;
    if (awvalid && awready) aw_log.push_back({awaddr, awlen});
    if (wvalid && wready) begin
      w_log.push_back({wlast, wdata});
      if (wlast) b_pend++;
    end
    if (tvalid && tready) s_idx++;
    t_hold = tvalid && !tready;
    if (bvalid && bready) begin b_pend--; b_cnt++; end
    if (prev_st) dr_after = desc_ready;
    prev_st = st_valid;
    if (st_valid) begin
      st_cnt++; st_err = st_error; st_cyc = cyc; st_dr = desc_ready;
    end
    cyc++;
  end

  // Reference: split the descriptor into page/max-length limited bursts.
  task automatic run(input logic [31:0] a, input int len, input int tl_at,
                     input int se_at, input bit stl);
    logic [39:0] exp_aw[$];
    logic [32:0] exp_w[$];
    logic [31:0] ca;
    logic [1:0]  exp_err;
    int n, cn, b, bnd, k, t0;
    n = len / STRB;
    s_data.delete(); aw_log.delete(); w_log.delete();
    for (int i = 0; i < n; i++) s_data.push_back($urandom);
    st_cnt = 0; b_cnt = 0; b_pend = 0; slverr_at = se_at; stall = stl;
    s_idx = 0; s_tlast_at = tl_at; dr_after = 1'b0;
    ca = a; cn = n; k = 0;
    while (cn > 0) begin
      b = 16;
      if (cn < b) b = cn;
      bnd = (4096 - int'(ca[11:0])) / STRB;
      if (bnd < b) b = bnd;
      exp_aw.push_back({ca, 8'(b - 1)});
      for (int j = 0; j < b; j++) begin
        exp_w.push_back({(j == b - 1), s_data[k]});
        k++;
      end
      ca = ca + 32'(b * STRB);
      cn -= b;
    end
    exp_err[1] = (n > 0) && (tl_at != n - 1);
    exp_err[0] = (se_at >= 0) && (se_at < exp_aw.size());
    d_addr = a; d_len = 9'(len); d_pend = 1;
    t0 = 0;
    while (st_cnt == 0 && t0 < 5000) begin @(negedge clk); t0++; end
    chk("status_timeout", 64'(st_cnt > 0), 64'd1);
    repeat (3) @(negedge clk);
    chk("status_count", 64'(st_cnt), 64'd1);
    chk("status_error", 64'(st_err), 64'(exp_err));
    chk("aw_count", 64'(aw_log.size()), 64'(exp_aw.size()));
    for (int i = 0; i < aw_log.size() && i < exp_aw.size(); i++)
      chk($sformatf("aw[%0d]", i), 64'(aw_log[i]), 64'(exp_aw[i]));
    chk("w_count", 64'(w_log.size()), 64'(exp_w.size()));
    for (int i = 0; i < w_log.size() && i < exp_w.size(); i++)
      chk($sformatf("w[%0d]", i), 64'(w_log[i]), 64'(exp_w[i]));
    if (n > 0) chk("aw_latency", 64'(aw_first_cyc - desc_cyc), 64'd1);
    else       chk("zero_len_status_latency", 64'(st_cyc - desc_cyc), 64'd2);
    chk("desc_ready_in_pulse", 64'(st_dr), 64'd0);
    chk("desc_ready_after_pulse", 64'(dr_after), 64'd1);
  endtask

  initial begin
    int t0, n, tl, se;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_desc_ready", 64'(desc_ready), 64'd0);
    chk("rst_valids", 64'({awvalid, wvalid, st_valid, bready, tready}), 64'd0);
    chk("rst_aw_fields", 64'({awaddr, awlen}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("idle_desc_ready", 64'(desc_ready), 64'd1);
    chk("const_fields", 64'({awid, awsize, awburst, awlock, awcache, awprot, wstrb}),
        64'({8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'hF}));

    run(32'h1000, 64, 15, -1, 0);
    run(32'h0FF8, 32, 7, -1, 0);
    run(32'h0000, 256, 63, -1, 1);
    run(32'h0000, 256, 63, 1, 1);
    run(32'h2000, 32, 4, -1, 0);
    run(32'h3000, 0, -1, -1, 0);

    // Reset in the middle of the second burst
    s_data.delete(); aw_log.delete(); w_log.delete();
    for (int i = 0; i < 64; i++) s_data.push_back($urandom);
    s_idx = 0; s_tlast_at = 63; slverr_at = -1; stall = 0; b_pend = 0; b_cnt = 0;
    d_addr = 32'h0; d_len = 9'd256; d_pend = 1;
    t0 = 0;
    while (w_log.size() < 20 && t0 < 2000) begin @(negedge clk); t0++; end
    chk("reach_burst2_timeout", 64'(w_log.size() >= 20), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("midrst_valids", 64'({awvalid, wvalid, st_valid, desc_ready}), 64'd0);
    s_data.delete(); s_idx = 0; t_hold = 0; b_pend = 0; d_pend = 0; st_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("midrst_no_status", 64'(st_cnt), 64'd0);
    chk("midrst_desc_ready", 64'(desc_ready), 64'd1);
    run(32'h4000, 64, 15, -1, 1);

    for (int r = 0; r < 8; r++) begin
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'(4096 - 4 * $urandom_range(1, 20));
      n  = $urandom_range(0, 127);
      tl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : n - 1;
      se = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
      run(a, n * STRB, tl, se, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_dma_wr_wrap.md
# axi_dma_wr_wrap

Write-direction DMA engine, the counterpart of the DMA read path. It accepts a write descriptor (address, byte length) and an AXI-stream payload. It issues AXI4 INCR write bursts (AW/W/B master) and pulses a completion status once every burst response has returned. Only aligned transfers are supported, with a fixed configuration, for use in the interconnect model.

## Interface
- AXI_DATA_WIDTH, 32: AXI W and AXI-stream data width; STRB = AXI_DATA_WIDTH/8 bytes per beat.
- AXI_ADDR_WIDTH, 32: address width.
- AXI_ID_WIDTH, 8: AWID/BID width.
- LEN_WIDTH, 9: descriptor byte-length width.
- AXI_MAX_BURST_LEN, 16: maximum beats per burst.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_axis_write_desc_addr  in  AXI_ADDR_WIDTH  start byte address; must be STRB-aligned.
- s_axis_write_desc_len  in  LEN_WIDTH  byte count; must be a multiple of STRB.
- s_axis_write_desc_valid / s_axis_write_desc_ready  in/out  1  descriptor handshake.
- m_axis_write_desc_status_valid  out  1  one-cycle completion pulse.
- m_axis_write_desc_status_error  out  2  bit0 = any BRESP≠OKAY; bit1 = tlast mismatch. Valid with status_valid.
- s_axis_write_data_tdata  in  AXI_DATA_WIDTH  payload.
- s_axis_write_data_tvalid / tready / tlast  in/out/in  1  stream handshake.
- m_axi_awid  out  AXI_ID_WIDTH  constant 0.
- m_axi_awaddr  out  AXI_ADDR_WIDTH  burst address.
- m_axi_awlen  out  8  beats-1.
- m_axi_awsize  out  3  constant log2(STRB).
- m_axi_awburst  out  2  constant 2'b01.
- m_axi_awlock  out  1  constant 0.
- m_axi_awcache  out  4  constant 4'b0011.
- m_axi_awprot  out  3  constant 0.
- m_axi_awvalid / m_axi_awready  out/in  1  AW handshake.
- m_axi_wdata  out  AXI_DATA_WIDTH  payload.
- m_axi_wstrb  out  STRB  all ones.
- m_axi_wlast  out  1  last beat of burst.
- m_axi_wvalid / m_axi_wready  out/in  1  W handshake.
- m_axi_bid  in  AXI_ID_WIDTH  response ID; ignored.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid / m_axi_bready  in/out  1  B handshake.

## Operation
- FSM states: IDLE, ADDR, DATA, WAIT_B.
- **IDLE**: desc_ready=1. On a descriptor handshake, latch addr and beats_left = len/STRB, then clear error bits.
  - If beats_left==0, go to WAIT_B.
  - Otherwise go to ADDR.
- **ADDR**: compute burst = min(beats_left, AXI_MAX_BURST_LEN, beats to next 4 KB boundary). Beats to the boundary = (4096 − addr[11:0])/STRB.
  - Drive awaddr=addr, awlen=burst−1, awvalid=1.
  - On awready, increment outstanding, load beat_cnt=burst, go to DATA.
- **DATA**: W passes through the stream combinationally.
  - wvalid=tvalid, tready=wready, wdata=tdata.
  - wlast=(beat_cnt==1).
  - On each W handshake, decrement beat_cnt and beats_left, and advance addr by STRB.
  - Tlast check: tlast≠(beats_left==1) on any beat sets error[1]. Data is never dropped or padded; exactly len/STRB beats are consumed.
  - After the final beat of a burst, go to ADDR if beats_left>0, else WAIT_B.
- **WAIT_B**: when outstanding==0, pulse status_valid with status_error and return to IDLE.
- **B channel**: bready=1 always, outside reset. Each B handshake decrements outstanding and ORs (bresp≠0) into error[0].
- **Counter rules**: simultaneous AW and B handshakes leave outstanding unchanged. Outstanding width is LEN_WIDTH bits.
- **Reset**: resets everything regardless of state. Outputs go to 0: desc_ready, status_valid, status_error, awvalid, wvalid, wlast, tready, bready, awaddr, awlen. Constant AXI fields are unaffected. Reset mid-operation abandons the transfer with no status.

## Timing
- A descriptor accepted at cycle T gives awvalid high at T+1.
- awvalid and AW fields stay stable until awready.
- The first W beat is possible in the cycle after the AW handshake. W has zero added latency.
- Burst-to-burst: one ADDR cycle minimum between the last W of one burst and the next awvalid.
- status_valid is asserted in the cycle after outstanding reaches 0 with all data sent. It lasts exactly 1 cycle.
- desc_ready returns high the cycle after the status pulse.
- A zero-length descriptor gives status_valid at T+2 with no AXI traffic.

## Test plan
- addr 0x1000, len 64, always-ready slave: one AW with awlen=15, 16 W beats with wlast on the 16th, status at error=00.
- addr 0xFF8, len 32: AW 0xFF8/awlen=1, then AW 0x1000/awlen=5; no burst crosses 4 KB; status error=00.
- addr 0x0, len 256: four bursts at 0x0/0x40/0x80/0xC0, each awlen=15. Random stalls on awready, wready, tvalid and bvalid; the data sequence must be preserved exactly.
- Same 4-burst transfer with bresp=SLVERR on the second B: all 64 beats written, status error=01 only after the 4th B.
- len 32 with tlast on beat 5: 8 beats still consumed, status error=10. Zero-length descriptor: status at T+2, no awvalid.
- Assert rst during DATA of burst 2: next cycle all valids=0 and desc_ready=0. After release desc_ready=1 and a fresh 64-byte descriptor completes normally.
